// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  // Byte source and memory side.
  modport master (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: assembles little-endian bytes into
// 32-bit words, writes them from index 0 upward and holds the core in reset
// while a program is loading.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              core_rst
);

  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              core_rst_q, core_rst_d;

  logic              len_ok;
  logic              last_word;

  assign len_ok    = (len != '0) && (len <= LEN_W'(DEPTH));
  assign last_word = ({1'b0, cnt_q} == (len_q - LEN_W'(1)));

  // Next-state and registered-output logic; outputs are decoded from the
  // next state so every output is a flop with no input-to-output path.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    err_d      = 1'b0;
    core_rst_d = core_rst_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d      = len;
            cnt_d      = '0;
            bcnt_d     = '0;
            core_rst_d = 1'b0;
            state_d    = S_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (bus.in_valid) begin
          asm_d[{bcnt_q, 3'b000} +: 8] = bus.in_data;
          if (bcnt_q == 2'd3) begin
            // Assembly lives in its own register so wdata only moves with we.
            wdata_d = {bus.in_data, asm_q[23:0]};
            waddr_d = cnt_q;
            state_d = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          bcnt_d  = '0;
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        core_rst_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_RECV);
    we_d       = (state_d == S_WRITE);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign core_rst     = core_rst_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle core. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into the instruction memory that the fetch stage reads by word index (`pc[31:2]`). It holds the core in reset while a program is loading and releases it when the load completes.

## Interface
- `DEPTH`, default 32: instruction memory size in words; must match the fetch-stage instruction memory.
- `ADDR_W`, default 5: word-address width, equal to log2(`DEPTH`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `len` in `ADDR_W`+1: number of words to load, sampled with `start`; legal range 1..`DEPTH`.
- `in_valid` in 1: byte on `in_data` is valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `we` out 1: instruction memory write strobe, one cycle per word.
- `waddr` out `ADDR_W`: word index being written.
- `wdata` out 32: assembled instruction word.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse when the last word has been written.
- `err` out 1: one-cycle pulse when `start` carries an illegal `len`.
- `core_rst` out 1: drives the core's reset, which is active-low. 0 holds the core in reset; 1 lets it run.

## Operation
- **States:** IDLE, RECV, WRITE, DONE.
- **IDLE:**
  - `start`=1 with 1 ≤ `len` ≤ `DEPTH`: latch `len`, clear the word and byte counters, set `busy`=1, drive `core_rst`=0, and go to RECV.
  - `start`=1 with `len`=0 or `len`>`DEPTH`: pulse `err` for one cycle and stay in IDLE. `core_rst` is unchanged.
- **RECV:**
  - `in_ready`=1. A byte transfers on any cycle where `in_valid` and `in_ready` are both 1.
  - Byte k (k = 0..3) goes to `wdata[8k+7:8k]`, so byte 0 is the LSB (RISC-V little-endian).
  - `in_valid`=0 stalls with no state change. There is no timeout.
  - On the 4th accepted byte, go to WRITE.
- **WRITE:**
  - `in_ready`=0 and `we`=1 for exactly one cycle, with `waddr` = word counter and `wdata` = the assembled word.
  - If word counter = latched `len`−1, go to DONE. Otherwise increment the word counter, clear the byte counter, and return to RECV.
- **DONE:** `done`=1 for one cycle, `busy`=0, then go to IDLE. `core_rst` goes to 1 on the same edge that leaves DONE.
- **`core_rst`:** stays 1 in IDLE after a successful load until the next legal `start`. A new legal `start` re-asserts reset (drives `core_rst`=0) for the whole reload.
- **`start` outside IDLE:** ignored; no `err`.
- **Addressing:** words are always written from `waddr`=0 upward. Words at indices ≥ `len` are not touched.
- **Output hold:** `wdata` and `waddr` hold their last values while `we`=0. Only `we` qualifies them.

## Timing
- **Reset values (all outputs):** state = IDLE; `in_ready`, `we`, `busy`, `done`, `err` = 0; `waddr` = 0; `wdata` = 0; `core_rst` = 0, so the core is held until the first load completes.
- **Asynchronous reset mid-load:** the load is abandoned and all outputs take their reset values immediately. Memory already written keeps its contents.
- **`start` to RECV:** `start` is sampled at edge 0; `busy`=1 and `in_ready`=1 from edge 0 onward.
- **Per-word throughput:** with `in_valid` held high, each word takes 5 cycles (4 accept cycles plus 1 WRITE cycle).
- **N-word load, no stalls:** the first `we` is in cycle 5 (counting cycle 1 as the first RECV cycle), the last `we` is in cycle 5N, `done` is in cycle 5N+1, and `core_rst`=1 from cycle 5N+2.
- **`err` and `done`:** each is a single-cycle pulse, registered (no combinational path from the inputs).
- **`in_ready`:** a registered function of state only; it does not depend on `in_valid`.

## Test plan
- **Reset:** assert `rst` asynchronously between clock edges. Every output must take its reset value before the next edge, including `core_rst`=0 and `we`=0.
- **Single-word load:** `start` with `len`=1, then bytes 13,00,00,00 with `in_valid` held high. Require exactly one `we` with `waddr`=0 and `wdata`=32'h00000013, `done` 1 cycle later, then `core_rst`=1.
- **Back-to-back 3-word load:** words 00206413, 00306493, 0280006f, sent as bytes LSB first with no stalls. Require `we` in cycles 5, 10 and 15 with `waddr` 0, 1, 2 and the matching `wdata`, `done` in cycle 16, and no extra `we`.
- **Stalls:** 2-word load with `in_valid` randomly deasserted. Require the same `waddr`/`wdata` sequence as the unstalled case and no byte accepted while `in_valid`=0. A `start` pulsed mid-load must be ignored.
- **Illegal length:** `start` with `len`=0, then `len`=33. Require an `err` pulse each time, the state staying in IDLE, `busy`=0, and no `we`.
- **Reload:** after a completed load, a second legal `start` must drive `core_rst`=0 for the whole reload. Assert `rst` mid-load to confirm the load aborts with no further `we`.
